logic_unit_pipe: RTL and testbench

- Parametrised, registered successor to the team's combinational bitwise logic block.
- Operation is selected per transaction, and the block carries a valid/ready handshake with backpressure.
- Optional accumulate mode takes operand B from the previous result. Status flags and a saturating transaction counter are also provided.
- Sits between operand producers and downstream datapath stages that need a clean one-stage registered boundary.

---
 rtl/logic_unit_pipe.sv | 102 ++++++++++
 tb/tb_logic_unit_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake, optional accumulate
// mode (operand B from the previous result), result flags and a saturating beat counter.
module logic_unit_pipe #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count
);

  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     b_eff;
  logic [W-1:0]     result;
  logic             accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // acc_clr on an accumulate beat substitutes zero for the stored accumulator
  always_comb begin
    b_eff = in_acc ? (acc_clr ? '0 : acc_q) : in_b;
    case (in_op)
      3'b000:  result = in_a & b_eff;
      3'b001:  result = in_a | b_eff;
      3'b010:  result = in_a ^ b_eff;
      3'b011:  result = ~in_a;
      3'b100:  result = ~(in_a & b_eff);
      3'b101:  result = ~(in_a | b_eff);
      3'b110:  result = ~(in_a ^ b_eff);
      default: result = in_a;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    count_d  = count_q;
    acc_d    = acc_q;
    if (accept) begin
      valid_d  = 1'b1;
      data_d   = result;
      zero_d   = (result == '0);
      parity_d = ^result;
      acc_d    = result;
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end
    end else begin
      if (out_ready) begin
        valid_d = 1'b0;
      end
      if (acc_clr) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
      count_q  <= '0;
      acc_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_zero   = zero_q;
  assign out_parity = parity_q;
  assign out_count  = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: a table of fixed vectors, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       in_acc;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic       out_parity;
  logic [15:0] out_count;

  logic       in_ready3;
  logic       out_valid3;
  logic [7:0] out_data3;
  logic       out_zero3;
  logic       out_parity3;
  logic [2:0] out_count3;

  logic_unit_pipe #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_parity(out_parity), .out_count(out_count)
  );

  // Narrow-counter copy sharing all inputs, so saturation at 7 is observable
  logic_unit_pipe #(.W(8), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_zero(out_zero3), .out_parity(out_parity3), .out_count(out_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;

  logic       m_valid;
  logic [7:0] m_data;
  logic       m_zero;
  logic       m_par;
  int         m_count;
  logic [7:0] m_acc;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    logic       zero;
    logic       par;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] op_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~a;
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  task automatic m_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_zero  = 1'b0;
    m_par   = 1'b0;
    m_count = 0;
    m_acc   = 8'h00;
  endtask

  task automatic check_outputs();
    int c3;
    c3 = (m_count > 7) ? 7 : m_count;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_zero", 32'(out_zero), 32'(m_zero));
    check("out_parity", 32'(out_parity), 32'(m_par));
    check("out_count", 32'(out_count), 32'(m_count));
    check("out_valid3", 32'(out_valid3), 32'(m_valid));
    check("out_data3", 32'(out_data3), 32'(m_data));
    check("out_count3", 32'(out_count3), 32'(c3));
  endtask

  // Called at a negedge; drives one cycle, checks in_ready, then checks outputs after the posedge
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic acc, input logic clr,
                       input logic ordy);
    logic       accept;
    logic [7:0] beff;
    logic [7:0] r;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    in_acc    = acc;
    acc_clr   = clr;
    out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    accept = v && (!m_valid || ordy);
    beff   = acc ? (clr ? 8'h00 : m_acc) : b;
    r      = op_fn(op, a, beff);
    @(posedge clk);
    #1;
    if (accept) begin
      m_valid = 1'b1;
      m_data  = r;
      m_zero  = (r == 8'h00);
      m_par   = ^r;
      m_acc   = r;
      if (m_count < 65535) m_count++;
    end else begin
      if (ordy) m_valid = 1'b0;
      if (clr) m_acc = 8'h00;
    end
    check_outputs();
    @(negedge clk);
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  int cnt0;

  initial begin
    total = 0;
    passed = 0;
    tbl[0] = '{3'd0, 8'hC3, 8'h5A, 8'h42, 1'b0, 1'b0};
    tbl[1] = '{3'd1, 8'hC3, 8'h5A, 8'hDB, 1'b0, 1'b0};
    tbl[2] = '{3'd2, 8'hC3, 8'h5A, 8'h99, 1'b0, 1'b0};
    tbl[3] = '{3'd3, 8'hC3, 8'h5A, 8'h3C, 1'b0, 1'b0};
    tbl[4] = '{3'd4, 8'hC3, 8'h5A, 8'hBD, 1'b0, 1'b0};
    tbl[5] = '{3'd5, 8'hC3, 8'h5A, 8'h24, 1'b0, 1'b0};
    tbl[6] = '{3'd6, 8'hC3, 8'h5A, 8'h66, 1'b0, 1'b0};
    tbl[7] = '{3'd7, 8'hC3, 8'h5A, 8'hC3, 1'b0, 1'b0};
    tbl[8] = '{3'd2, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0};
    tbl[9] = '{3'd1, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0;
    in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Fixed vectors: all ops, zero and parity corners
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b0, 1'b0, 1'b1);
      check($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].exp));
      check($sformatf("tbl%0d_zero", i), 32'(out_zero), 32'(tbl[i].zero));
      check($sformatf("tbl%0d_par", i), 32'(out_parity), 32'(tbl[i].par));
      if (i == 7) check("tbl_count8", 32'(out_count), 32'd8);
    end

    // Backpressure: one accept, then held output, then no-bubble resume
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    cnt0 = m_count;
    cycle(1'b1, 8'hAA, 8'h0F, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("bp_ready", 32'(in_ready), 32'd0);
      cycle(1'b1, 8'h55, 8'h55, 3'd1, 1'b0, 1'b0, 1'b0);
      check("bp_data", 32'(out_data), 32'h0A);
    end
    check("bp_count", 32'(out_count), 32'(cnt0 + 1));
    cycle(1'b1, 8'h3C, 8'hFF, 3'd7, 1'b0, 1'b0, 1'b1);
    check("bp_resume_valid", 32'(out_valid), 32'd1);
    check("bp_resume_data", 32'(out_data), 32'h3C);
    check("bp_resume_count", 32'(out_count), 32'(cnt0 + 2));

    // Accumulate chain with XOR
    cycle(1'b1, 8'h0F, 8'hEE, 3'd2, 1'b1, 1'b1, 1'b1);
    check("acc1", 32'(out_data), 32'h0F);
    cycle(1'b1, 8'hF0, 8'hEE, 3'd2, 1'b1, 1'b0, 1'b1);
    check("acc2", 32'(out_data), 32'hFF);
    cycle(1'b1, 8'hFF, 8'hEE, 3'd2, 1'b1, 1'b0, 1'b1);
    check("acc3", 32'(out_data), 32'h00);
    cycle(1'b1, 8'h77, 8'hEE, 3'd2, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 8'h33, 8'hEE, 3'd2, 1'b1, 1'b0, 1'b1);
    check("acc_clr_idle", 32'(out_data), 32'h33);

    // Counter saturation on the narrow copy
    sync_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
    check("sat_count3", 32'(out_count3), 32'd7);
    check("sat_count16", 32'(out_count), 32'd10);

    // Asynchronous reset while holding a valid result
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h81, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1);
    check("post_reset_acc", 32'(out_data), 32'h00);
    check("post_reset_count", 32'(out_count), 32'd1);

    // Randomized traffic, including don't-care inputs while idle
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
